// File: rtl/md_sched.sv
//----------------------------------------------------------------------------
// Module      : md_sched
// Description : Multiply/divide scheduler for a MIPS-style pipeline. Accepts
//               mult/multu/div/divu/mthi/mtlo (and madd/maddu), holds the
//               unit busy for a fixed latency, then pulses the hi/lo register
//               file write enables for one cycle. Raises stall when a new
//               request or an mfhi/mflo arrives while an operation is live.
// Config      : define MD_SCHED_MADD_EN to enable madd/maddu accumulation;
//               otherwise ops 6/7 are accepted and discarded.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [31:0] hio,
  input  logic [31:0] lio,
  input  logic        mfreq,
  output logic        busy,
  output logic        stall,
  output logic        hiwrite,
  output logic        lowrite,
  output logic [31:0] hidata,
  output logic [31:0] lodata
);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;
  localparam logic [2:0] c_OP_MADD  = 3'd6;
  localparam logic [2:0] c_OP_MADDU = 3'd7;

  localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        hiwrite_q, hiwrite_d;
  logic        lowrite_q, lowrite_d;
  logic [31:0] hidata_q, hidata_d;
  logic [31:0] lodata_q, lodata_d;

`ifdef MD_SCHED_MADD_EN
  // Accumulator snapshot of hi/lo taken at accept for madd/maddu.
  logic [31:0] hacc_q, hacc_d;
  logic [31:0] lacc_q, lacc_d;
`else
  // hi/lo inputs only feed the accumulate path.
  logic w_unused;
  assign w_unused = ^{hio, lio};
`endif

  // Datapath wires, all evaluated from the captured operands.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_dvd, w_dvs, w_dvs_safe;
  logic        w_dvs_zero;
  logic [31:0] w_q_u, w_r_u;
  logic [31:0] w_quot, w_rem;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_res_we;

  // Products and sign-magnitude division. Division is done on magnitudes so
  // 0x80000000 / -1 naturally yields 0x80000000 with zero remainder.
  always_comb begin
    w_prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    w_prod_u     = {32'd0, a_q} * {32'd0, b_q};
    w_div_signed = (op_q == c_OP_DIV);
    w_a_neg      = w_div_signed & a_q[31];
    w_b_neg      = w_div_signed & b_q[31];
    w_dvd        = w_a_neg ? (32'd0 - a_q) : a_q;
    w_dvs        = w_b_neg ? (32'd0 - b_q) : b_q;
    w_dvs_zero   = (b_q == 32'd0);
    w_dvs_safe   = w_dvs_zero ? 32'd1 : w_dvs;
    w_q_u        = w_dvd / w_dvs_safe;
    w_r_u        = w_dvd % w_dvs_safe;
    w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_u) : w_q_u;
    w_rem        = w_a_neg ? (32'd0 - w_r_u) : w_r_u;
  end

  // Select the hi/lo result and whether it is written back.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_we = 1'b0;
    case (op_q)
      c_OP_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_res_we = 1'b1;
      end
      c_OP_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_res_we = 1'b1;
      end
      c_OP_DIV, c_OP_DIVU: begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
        // A zero divisor leaves hi/lo untouched.
        w_res_we = ~w_dvs_zero;
      end
`ifdef MD_SCHED_MADD_EN
      c_OP_MADD: begin
        {w_res_hi, w_res_lo} = {hacc_q, lacc_q} + w_prod_s;
        w_res_we = 1'b1;
      end
      c_OP_MADDU: begin
        {w_res_hi, w_res_lo} = {hacc_q, lacc_q} + w_prod_u;
        w_res_we = 1'b1;
      end
`endif
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, count down in BUSY, one-cycle WB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hiwrite_d = 1'b0;
    lowrite_d = 1'b0;
    hidata_d  = 32'd0;
    lodata_d  = 32'd0;
`ifdef MD_SCHED_MADD_EN
    hacc_d    = hacc_q;
    lacc_d    = lacc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            c_OP_MULT, c_OP_MULTU: begin
              op_d    = op;
              a_d     = srca;
              b_d     = srcb;
              cnt_d   = c_MULT_CNT;
              state_d = S_BUSY;
            end
            c_OP_DIV, c_OP_DIVU: begin
              op_d    = op;
              a_d     = srca;
              b_d     = srcb;
              cnt_d   = c_DIV_CNT;
              state_d = S_BUSY;
            end
            c_OP_MTHI: begin
              hiwrite_d = 1'b1;
              hidata_d  = srca;
              state_d   = S_WB;
            end
            c_OP_MTLO: begin
              lowrite_d = 1'b1;
              lodata_d  = srca;
              state_d   = S_WB;
            end
`ifdef MD_SCHED_MADD_EN
            c_OP_MADD, c_OP_MADDU: begin
              op_d    = op;
              a_d     = srca;
              b_d     = srcb;
              hacc_d  = hio;
              lacc_d  = lio;
              cnt_d   = c_MULT_CNT;
              state_d = S_BUSY;
            end
`endif
            default: begin
              // madd/maddu without the accumulate feature: accepted, dropped.
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          state_d   = S_WB;
          hiwrite_d = w_res_we;
          lowrite_d = w_res_we;
          hidata_d  = w_res_we ? w_res_hi : 32'd0;
          lodata_d  = w_res_we ? w_res_lo : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, operand and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      hiwrite_q <= 1'b0;
      lowrite_q <= 1'b0;
      hidata_q  <= 32'd0;
      lodata_q  <= 32'd0;
`ifdef MD_SCHED_MADD_EN
      hacc_q    <= 32'd0;
      lacc_q    <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hiwrite_q <= hiwrite_d;
      lowrite_q <= lowrite_d;
      hidata_q  <= hidata_d;
      lodata_q  <= lodata_d;
`ifdef MD_SCHED_MADD_EN
      hacc_q    <= hacc_d;
      lacc_q    <= lacc_d;
`endif
    end
  end

  assign busy    = (state_q == S_BUSY);
  assign stall   = ((state_q == S_BUSY) || (state_q == S_WB)) && (start || mfreq);
  assign hiwrite = hiwrite_q;
  assign lowrite = lowrite_q;
  assign hidata  = hidata_q;
  assign lodata  = lodata_q;

endmodule

`default_nettype wire

// File: tb/tb_md_sched.sv
//----------------------------------------------------------------------------
// Module      : tb_md_sched
// Description : Scoreboard bench for md_sched. Stimulus pushes expected hi/lo
//               write-back records; a monitor pops and compares on every
//               write pulse. Honours MD_SCHED_MADD_EN for madd/maddu.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srca, srcb, hio, lio;
  logic        mfreq;
  logic        busy, stall, hiwrite, lowrite;
  logic [31:0] hidata, lodata;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .hio     (hio),
    .lio     (lio),
    .mfreq   (mfreq),
    .busy    (busy),
    .stall   (stall),
    .hiwrite (hiwrite),
    .lowrite (lowrite),
    .hidata  (hidata),
    .lodata  (lodata)
  );

  typedef struct packed {
    logic        hw;
    logic        lw;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic hw, input logic lw, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hw = hw; e.lw = lw; e.hi = hi; e.lo = lo;
    sb_q.push_back(e);
  endtask

  // Count busy cycles until busy drops, then step past WB and confirm idle outputs.
  task automatic wait_done(input int exp_n, input string name);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1'b1;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
    @(posedge clk);
    #1;
    check({name, "_idle_clear"}, {31'd0, hiwrite | lowrite, hidata | lodata}, 64'd0);
  endtask

  // Issue one op, scramble all operand inputs after accept, wait completion.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l,
                       input int exp_n, input string name);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    hio   = h;
    lio   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
    hio   = $urandom;
    lio   = $urandom;
    wait_done(exp_n, name);
  endtask

  // Monitor: every write pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && (hiwrite || lowrite)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wb", {62'd0, hiwrite, lowrite}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_hiwrite", {63'd0, hiwrite}, {63'd0, mon_e.hw});
        check("wb_lowrite", {63'd0, lowrite}, {63'd0, mon_e.lw});
        if (mon_e.hw) check("wb_hidata", {32'd0, hidata}, {32'd0, mon_e.hi});
        if (mon_e.lw) check("wb_lodata", {32'd0, lodata}, {32'd0, mon_e.lo});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  done;
    reset = 1'b1;
    start = 1'b1;
    mfreq = 1'b1;
    op    = 3'd0;
    srca  = 32'd0;
    srcb  = 32'd0;
    hio   = 32'd0;
    lio   = 32'd0;

    // Reset state, with requests present to show stall stays low in IDLE.
    repeat (2) @(negedge clk);
    check("rst_busy",   {63'd0, busy},  64'd0);
    check("rst_stall",  {63'd0, stall}, 64'd0);
    check("rst_writes", {62'd0, hiwrite, lowrite}, 64'd0);
    check("rst_data",   {hidata, lodata}, 64'd0);
    start = 1'b0;
    mfreq = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Multiply: signed and unsigned.
    push(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 5, "mult");
    push(1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5, "multu");

    // Divide: unsigned, signed, overflow corner, negative divisor, zero divisor.
    push(1'b1, 1'b1, 32'd1, 32'd3);
    do_op(3'd3, 32'd7, 32'd2, 32'd0, 32'd0, 10, "divu");
    push(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 10, "div_neg");
    push(1'b1, 1'b1, 32'd0, 32'h80000000);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 10, "div_ovf");
    push(1'b1, 1'b1, 32'd1, 32'hFFFFFFFD);
    do_op(3'd2, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 10, "div_negdvs");
    do_op(3'd2, 32'd5, 32'd0, 32'd0, 32'd0, 10, "div_zero");

    // Moves to hi/lo: single write one cycle after start.
    push(1'b1, 1'b0, 32'h12345678, 32'd0);
    do_op(3'd4, 32'h12345678, 32'd0, 32'd0, 32'd0, 0, "mthi");
    push(1'b0, 1'b1, 32'd0, 32'hCAFEF00D);
    do_op(3'd5, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0, 0, "mtlo");

`ifdef MD_SCHED_MADD_EN
    push(1'b1, 1'b1, 32'd1, 32'd0);
    do_op(3'd7, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 5, "maddu");
    push(1'b1, 1'b1, 32'd0, 32'd2);
    do_op(3'd6, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd5, 5, "madd");
`else
    do_op(3'd7, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, "maddu_noop");
    do_op(3'd6, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd5, 0, "madd_noop");
`endif

    // Stall: mfreq and a held second start during busy; stall through WB.
    push(1'b1, 1'b1, 32'd1, 32'd0);
    push(1'b1, 1'b1, 32'd1, 32'hFFFFFFFE);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    srca  = 32'h00010000;
    srcb  = 32'h00010000;
    @(posedge clk);
    #1;
    op    = 3'd1;
    srca  = 32'hFFFFFFFF;
    srcb  = 32'd2;
    mfreq = 1'b1;
    cnt   = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall) cnt++;
      else done = 1'b1;
    end
    check("stall_cycles", 64'(cnt), 64'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    mfreq = 1'b0;
    check("second_accept", {63'd0, busy}, 64'd1);
    wait_done(5, "stalled_multu");

    // Reset mid-BUSY aborts; first start after release is accepted at once.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd2;
    srca  = 32'd100;
    srcb  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_abort_busy",   {63'd0, busy}, 64'd0);
    check("rst_abort_writes", {62'd0, hiwrite, lowrite}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd0;
    srca  = 32'd2;
    srcb  = 32'd3;
    push(1'b1, 1'b1, 32'd0, 32'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_accept", {63'd0, busy}, 64'd1);
    wait_done(5, "post_rst_mult");

    repeat (15) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
